accumulator_ctrl: RTL and testbench

Sequencing controller for the K-means accumulate phase. It owns centroid_num accumulator registers and their point counters, and accepts classified points over a valid/ready stream. For each point it routes the selected accumulator through one shared accumulator_adder instance and writes the sum back. After the last point it streams every per-centroid sum and count to the centroid-update stage.

---
 rtl/kmeans_pkg.sv | 20 ++
 rtl/accumulator_adder.sv | 24 ++
 rtl/accumulator_ctrl.sv | 177 +++++++++++++++++
 tb/tb_accumulator_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kmeans_pkg.sv
// Shared widths and controller state encoding for the K-means accumulate phase.
package kmeans_pkg;

    localparam int dataWidth        = 91;
    localparam int cordinate_width  = 13;
    localparam int accum_cord_width = 22;
    localparam int accum_width      = 154;
    localparam int centroid_num     = 8;
    localparam int count_width      = 10;
    localparam int idx_width        = 3;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        FLUSH,
        READOUT
    } ctrl_state_t;

endpackage

// File: rtl/accumulator_adder.sv
// Per-coordinate sign-extending adder: acc + sext(point), each lane wraps mod 2^accum_cord_width.
module accumulator_adder #(
    parameter int dataWidth        = kmeans_pkg::dataWidth,
    parameter int cordinate_width  = kmeans_pkg::cordinate_width,
    parameter int accum_cord_width = kmeans_pkg::accum_cord_width,
    parameter int accum_width      = kmeans_pkg::accum_width
) (
    input  logic [accum_width-1:0] acc,
    input  logic [dataWidth-1:0]   point,
    output logic [accum_width-1:0] sum
);

    localparam int cord_num = dataWidth / cordinate_width;
    localparam int ext_bits = accum_cord_width - cordinate_width;

    for (genvar i = 0; i < cord_num; i++) begin : g_cord
        logic [cordinate_width-1:0] cord;
        assign cord = point[i*cordinate_width +: cordinate_width];
        assign sum[i*accum_cord_width +: accum_cord_width] =
            acc[i*accum_cord_width +: accum_cord_width] +
            {{ext_bits{cord[cordinate_width-1]}}, cord};
    end

endmodule

// File: rtl/accumulator_ctrl.sv
// K-means accumulate controller: per-centroid sums/counts fed by a point stream,
// updated through one shared adder, then streamed out entry by entry.
module accumulator_ctrl #(
    parameter int dataWidth        = kmeans_pkg::dataWidth,
    parameter int cordinate_width  = kmeans_pkg::cordinate_width,
    parameter int accum_cord_width = kmeans_pkg::accum_cord_width,
    parameter int accum_width      = kmeans_pkg::accum_width,
    parameter int centroid_num     = kmeans_pkg::centroid_num,
    parameter int count_width      = kmeans_pkg::count_width,
    parameter int idx_width        = kmeans_pkg::idx_width
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   pt_valid,
    output logic                   pt_ready,
    input  logic [dataWidth-1:0]   pt_data,
    input  logic [idx_width-1:0]   pt_idx,
    input  logic                   pt_last,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [idx_width-1:0]   rd_idx,
    output logic [accum_width-1:0] rd_accum,
    output logic [count_width-1:0] rd_count,
    output logic                   done,
    output logic                   busy,
    output logic                   idx_err,
    output logic                   cnt_ovf
);

    import kmeans_pkg::*;

    localparam logic [count_width-1:0] cnt_max = '1;
    localparam logic [idx_width-1:0]   last_e  = idx_width'(centroid_num - 1);

    ctrl_state_t state, state_nxt;

    logic [accum_width-1:0] acc   [centroid_num];
    logic [count_width-1:0] count [centroid_num];

    logic                   st_valid;
    logic [dataWidth-1:0]   st_data;
    logic [idx_width-1:0]   st_idx;

    logic [idx_width-1:0]   entry, entry_nxt;
    logic                   done_nxt;
    logic                   accept, idx_ok;
    logic [accum_width-1:0] sel_acc, sum, rd_sel_acc;
    logic [count_width-1:0] rd_sel_cnt;

    assign accept = pt_valid && (state == ACCUM);

    // Index decode by compare so out-of-range indices never address storage.
    always_comb begin
        idx_ok     = 1'b0;
        sel_acc    = '0;
        rd_sel_acc = '0;
        rd_sel_cnt = '0;
        for (int i = 0; i < centroid_num; i++) begin
            if (pt_idx == idx_width'(i)) idx_ok = 1'b1;
            if (st_idx == idx_width'(i)) sel_acc = acc[i];
            if (entry == idx_width'(i)) begin
                rd_sel_acc = acc[i];
                rd_sel_cnt = count[i];
            end
        end
    end

    accumulator_adder #(
        .dataWidth       (dataWidth),
        .cordinate_width (cordinate_width),
        .accum_cord_width(accum_cord_width),
        .accum_width     (accum_width)
    ) u_adder (
        .acc  (sel_acc),
        .point(st_data),
        .sum  (sum)
    );

    always_comb begin
        state_nxt = state;
        entry_nxt = entry;
        done_nxt  = 1'b0;
        pt_ready  = 1'b0;
        rd_valid  = 1'b0;
        busy      = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (start) state_nxt = CLEAR;
            end
            CLEAR: begin
                state_nxt = ACCUM;
            end
            ACCUM: begin
                pt_ready = 1'b1;
                if (pt_valid && pt_last) state_nxt = FLUSH;
            end
            FLUSH: begin
                state_nxt = READOUT;
                entry_nxt = '0;
            end
            READOUT: begin
                rd_valid = 1'b1;
                if (rd_ready) begin
                    if (entry == last_e) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        entry_nxt = entry + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rd_idx   = rd_valid ? entry : '0;
    assign rd_accum = rd_valid ? rd_sel_acc : '0;
    assign rd_count = rd_valid ? rd_sel_cnt : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            entry <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            entry <= entry_nxt;
            done  <= done_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_valid <= 1'b0;
            st_data  <= '0;
            st_idx   <= '0;
        end else begin
            st_valid <= accept && idx_ok;
            if (accept) begin
                st_data <= pt_data;
                st_idx  <= pt_idx;
            end
        end
    end

    // Stage 2 writes land before the next point reads, so no bypass is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < centroid_num; i++) begin
                acc[i]   <= '0;
                count[i] <= '0;
            end
            idx_err <= 1'b0;
            cnt_ovf <= 1'b0;
        end else if (state == CLEAR) begin
            for (int i = 0; i < centroid_num; i++) begin
                acc[i]   <= '0;
                count[i] <= '0;
            end
            idx_err <= 1'b0;
            cnt_ovf <= 1'b0;
        end else begin
            if (accept && !idx_ok) idx_err <= 1'b1;
            if (st_valid) begin
                for (int i = 0; i < centroid_num; i++) begin
                    if (st_idx == idx_width'(i)) begin
                        acc[i] <= sum;
                        if (count[i] == cnt_max) cnt_ovf <= 1'b1;
                        else count[i] <= count[i] + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_accumulator_ctrl.sv
// Bench for accumulator_ctrl: per-coordinate integer model plus literal spot checks.
module tb_accumulator_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, pt_valid, pt_last, rd_ready;
    logic [90:0]  pt_data;
    logic [2:0]   pt_idx;
    logic         pt_ready, rd_valid, done, busy, idx_err, cnt_ovf;
    logic [2:0]   rd_idx;
    logic [153:0] rd_accum;
    logic [9:0]   rd_count;

    logic         s_start, s_pt_valid, s_pt_last, s_rd_ready;
    logic [90:0]  s_pt_data;
    logic [3:0]   s_pt_idx;
    logic         s_pt_ready, s_rd_valid, s_done, s_busy, s_idx_err, s_cnt_ovf;
    logic [3:0]   s_rd_idx;
    logic [153:0] s_rd_accum;
    logic [1:0]   s_rd_count;

    always #5 clk = ~clk;

    accumulator_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
        .pt_idx(pt_idx), .pt_last(pt_last),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_idx(rd_idx),
        .rd_accum(rd_accum), .rd_count(rd_count),
        .done(done), .busy(busy), .idx_err(idx_err), .cnt_ovf(cnt_ovf)
    );

    accumulator_ctrl #(.count_width(2), .idx_width(4)) u_small (
        .clk(clk), .rst_n(rst_n), .start(s_start),
        .pt_valid(s_pt_valid), .pt_ready(s_pt_ready), .pt_data(s_pt_data),
        .pt_idx(s_pt_idx), .pt_last(s_pt_last),
        .rd_valid(s_rd_valid), .rd_ready(s_rd_ready), .rd_idx(s_rd_idx),
        .rd_accum(s_rd_accum), .rd_count(s_rd_count),
        .done(s_done), .busy(s_busy), .idx_err(s_idx_err), .cnt_ovf(s_cnt_ovf)
    );

    int checks = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Model: plain integer sums per centroid and coordinate.
    int msum [8][7];
    int mcnt [8];

    task automatic model_clear();
        for (int e = 0; e < 8; e++) begin
            mcnt[e] = 0;
            for (int c = 0; c < 7; c++) msum[e][c] = 0;
        end
    endtask

    task automatic model_add(input int idx, input logic [90:0] d);
        logic signed [12:0] v;
        if (idx < 8) begin
            for (int c = 0; c < 7; c++) begin
                v = d[c*13 +: 13];
                msum[idx][c] += int'(v);
            end
            if (mcnt[idx] < 1023) mcnt[idx]++;
        end
    endtask

    function automatic logic [153:0] m_acc(input int e);
        logic [153:0] r;
        int s;
        r = '0;
        for (int c = 0; c < 7; c++) begin
            s = msum[e][c];
            r[c*22 +: 22] = s[21:0];
        end
        return r;
    endfunction

    // Per-cycle readout comparison against the model.
    int exp_e = 0;
    bit done_pend = 1'b0;
    int done_cnt = 0;
    logic [153:0] cap_acc [8];
    logic [9:0]   cap_cnt [8];

    always @(negedge clk) begin
        if (rst_n) begin
            chk("done", done, done_pend);
            if (done) done_cnt++;
            done_pend = 1'b0;
            if (rd_valid) begin
                chk("rd_idx", rd_idx, exp_e);
                chk("rd_accum", rd_accum, m_acc(exp_e));
                chk("rd_count", rd_count, mcnt[exp_e]);
                cap_acc[exp_e[2:0]] = rd_accum;
                cap_cnt[exp_e[2:0]] = rd_count;
                if (rd_ready) begin
                    if (exp_e == 7) begin
                        done_pend = 1'b1;
                        exp_e = 0;
                    end else begin
                        exp_e++;
                    end
                end
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input int idx, input logic [90:0] d, input bit last, output int waits);
        bit r;
        pt_valid = 1'b1;
        pt_data  = d;
        pt_idx   = idx[2:0];
        pt_last  = last;
        waits = 0;
        r = 1'b0;
        while (!r && waits <= 50) begin
            @(negedge clk);
            r = pt_ready;
            @(posedge clk); #1;
            if (!r) waits++;
        end
        if (!r) begin
            checks++;
            $display("FAIL send_timeout: got no pt_ready expected pt_ready");
        end else begin
            model_add(idx, d);
        end
        pt_valid = 1'b0;
        pt_last  = 1'b0;
    endtask

    task automatic readout(input int stall_e, input bit poke, output int stalled);
        int d0;
        bit poked;
        d0 = done_cnt;
        stalled = 0;
        poked = 1'b0;
        rd_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && done_cnt == d0; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (rd_valid && int'(rd_idx) == stall_e && stalled < 5) begin
                rd_ready = 1'b0;
                stalled++;
            end else begin
                rd_ready = 1'b1;
            end
            if (poke && !poked && rd_valid && rd_idx == 3'd4) begin
                start = 1'b1;
                poked = 1'b1;
            end
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("done_once", done_cnt - d0, 1);
        chk("idle_after_done", {busy, rd_valid}, 2'b00);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_pt_ready"}, pt_ready, 1'b0);
        chk({tag, "_rd_valid"}, rd_valid, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_flags"}, {idx_err, cnt_ovf}, 2'b00);
        chk({tag, "_rd_fields"}, {rd_idx, rd_count, rd_accum}, '0);
    endtask

    task automatic s_send(input int idx, input logic [90:0] d, input bit last);
        bit r;
        int w;
        s_pt_valid = 1'b1;
        s_pt_data  = d;
        s_pt_idx   = idx[3:0];
        s_pt_last  = last;
        r = 1'b0;
        w = 0;
        while (!r && w <= 50) begin
            @(negedge clk);
            r = s_pt_ready;
            @(posedge clk); #1;
            w++;
        end
        if (!r) begin
            checks++;
            $display("FAIL s_send_timeout: got no pt_ready expected pt_ready");
        end
        s_pt_valid = 1'b0;
        s_pt_last  = 1'b0;
    endtask

    initial begin
        int w, wsum, st;
        logic [1:0]   s_cnt1;
        logic [153:0] s_acc1;
        bit s_done_seen;

        rst_n = 1'b0;
        start = 0; pt_valid = 0; pt_last = 0; pt_data = '0; pt_idx = '0; rd_ready = 1;
        s_start = 0; s_pt_valid = 0; s_pt_last = 0; s_pt_data = '0; s_pt_idx = '0; s_rd_ready = 1;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic: +5 then -3 into idx0
        pulse_start();
        chk("busy_clear", busy, 1'b1);
        model_clear();
        send(0, {7{13'd5}}, 1'b0, w);
        send(0, {7{13'h1FFD}}, 1'b1, w);
        chk("pt_ready_drop", pt_ready, 1'b0);
        readout(-1, 1'b0, st);
        chk("basic_acc0", cap_acc[0], {7{22'd2}});
        chk("basic_cnt0", cap_cnt[0], 10'd2);
        chk("basic_acc1", cap_acc[1], 154'd0);
        chk("basic_cnt7", cap_cnt[7], 10'd0);

        // Sign extension
        pulse_start();
        model_clear();
        send(2, {13'h0FFF, 65'd0, 13'h1FFF}, 1'b1, w);
        readout(-1, 1'b0, st);
        chk("sext_c0", cap_acc[2][21:0], 22'h3FFFFF);
        chk("sext_c6", cap_acc[2][153:132], 22'h000FFF);
        chk("sext_mid", cap_acc[2][131:22], 110'd0);
        chk("sext_cnt", cap_cnt[2], 10'd1);

        // Back-to-back into idx5
        pulse_start();
        model_clear();
        wsum = 0;
        for (int k = 0; k < 8; k++) begin
            send(5, {7{13'd1}}, k == 7, w);
            if (k > 0) wsum += w;
        end
        chk("b2b_no_stall", wsum, 0);
        readout(-1, 1'b0, st);
        chk("b2b_acc5", cap_acc[5], {7{22'd8}});
        chk("b2b_cnt5", cap_cnt[5], 10'd8);

        // Backpressure at entry 3
        pulse_start();
        model_clear();
        send(3, {7{13'd100}}, 1'b0, w);
        send(7, {13'd1, 13'd2, 13'd3, 13'd4, 13'd5, 13'd6, 13'h1FF0}, 1'b0, w);
        send(3, {7{13'h1F00}}, 1'b1, w);
        readout(3, 1'b0, st);
        chk("bp_stalls", st, 5);
        chk("bp_acc3", cap_acc[3], {7{22'h3FFF64}});
        chk("bp_cnt3", cap_cnt[3], 10'd2);
        chk("bp_acc7_c0", cap_acc[7][21:0], 22'h3FFFF0);

        // Saturating counter and index error on the small build
        @(posedge clk); #1;
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        for (int k = 0; k < 5; k++) s_send(1, {7{13'd1}}, 1'b0);
        s_send(9, {7{13'd1}}, 1'b1);
        s_cnt1 = '0;
        s_acc1 = '0;
        s_done_seen = 1'b0;
        for (int cyc = 0; cyc < 100 && !s_done_seen; cyc++) begin
            @(negedge clk);
            if (s_rd_valid && s_rd_idx == 4'd1) begin
                s_cnt1 = s_rd_count;
                s_acc1 = s_rd_accum;
            end
            if (s_done) s_done_seen = 1'b1;
        end
        chk("ovf_done", s_done_seen, 1'b1);
        chk("ovf_cnt1", s_cnt1, 2'd3);
        chk("ovf_acc1", s_acc1, {7{22'd5}});
        chk("ovf_flags", {s_cnt_ovf, s_idx_err}, 2'b11);
        @(posedge clk); #1;
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        @(posedge clk); #1;
        chk("ovf_cleared", {s_cnt_ovf, s_idx_err, s_pt_ready}, 3'b001);

        // Reset during ACCUM
        pulse_start();
        model_clear();
        send(6, {7{13'd9}}, 1'b0, w);
        send(6, {7{13'd9}}, 1'b0, w);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("abort");
        exp_e = 0;
        done_pend = 1'b0;
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;

        // start during READOUT is ignored
        pulse_start();
        model_clear();
        send(4, {7{13'd7}}, 1'b1, w);
        readout(-1, 1'b1, st);
        chk("ign_acc4", cap_acc[4], {7{22'd7}});
        chk("ign_cnt4", cap_cnt[4], 10'd1);
        chk("ign_acc6", cap_acc[6], 154'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
